suma_bcd_serial: RTL and testbench
==================================

Name: suma_bcd_serial

Overview:
- Downstream consumer of the save/hold stage. On a one-cycle `suma` pulse it adds the stored operand to the live operand from the digit-entry path.
- Addition is digit-serial BCD, one digit per clock, least-significant digit first.
- Produces an (N_DIGITS+1)-digit BCD result for the display/decoder path, plus a one-cycle `listo` strobe.

Parameters:
- N_DIGITS, 4, number of BCD digits per operand; result has N_DIGITS+1 digits.

Ports:
- clk  input  1  system clock
- rst  input  1  global reset; synchronous, active-high
- operando_a  input  [N_DIGITS-1:0][3:0]  stored operand (from save stage numero_sv); digit 0 = LSD
- operando_b  input  [N_DIGITS-1:0][3:0]  live operand (from digit-entry stage)
- suma  input  1  start pulse; sampled on clk rising edge
- rst_sv  input  1  clear request; same effect as rst on this block
- resultado  output  [N_DIGITS:0][3:0]  BCD sum; digit N_DIGITS is carry digit (0 or 1)
- ocupado  output  1  high while addition in progress
- listo  output  1  one-cycle pulse when resultado is final
- error_bcd  output  1  invalid-digit flag (see Optional Feature; tied 0 when disabled)

Behaviour:
- Reset (rst or rst_sv high at a clk edge): state=REPOSO, resultado=0, ocupado=0, listo=0, error_bcd=0, digit index=0, carry=0. Reset has priority over suma and aborts any operation in progress; no listo is produced for the aborted operation.
- States: REPOSO, SUMANDO, FIN.
- REPOSO:
  - listo=0.
  - On suma=1: latch operando_a/b into internal copies, clear resultado to 0, idx=0, carry=0, ocupado=1, go to SUMANDO.
  - Inputs may change after the suma edge without affecting the result.
- SUMANDO, each cycle:
  - s = a[idx] + b[idx] + carry, computed 5 bits wide.
  - If s > 9: resultado[idx] = (s+6)[3:0], carry=1. Otherwise resultado[idx] = s[3:0], carry=0.
  - idx increments.
  - After digit N_DIGITS-1, go to FIN.
- FIN (one cycle):
  - resultado[N_DIGITS] = {3'b0, carry}; listo=1; ocupado=0.
  - Next cycle: return to REPOSO.
- Latency: suma sampled at edge T → listo high during cycle T+N_DIGITS+1 (5 cycles for default).
- resultado is held stable after FIN until the next accepted suma or a reset.
- suma while ocupado=1 or in FIN: ignored, no queuing.
- suma held high for several cycles: only the first edge in REPOSO starts an operation; a re-trigger is possible the cycle after returning to REPOSO.
- Partial resultado digits are visible during SUMANDO; consumers use listo only.
- No wrap-around: max 9999+9999=19998 fits in the result width.

Optional Feature:
- Macro: SUMA_BCD_CHECK_EN.
- Defined:
  - At the accepted suma, error_bcd=1 if any digit of operando_a or operando_b > 9.
  - The addition still runs with the same arithmetic; resultado is unspecified-but-deterministic.
  - error_bcd holds until the next accepted suma or a reset.
- Undefined: error_bcd tied to 0 and no checking logic is generated.

Decomposition:
- Shared package suma_pkg:
  - estado_suma_t enum {REPOSO, SUMANDO, FIN}
  - typedef bcd_t = logic [3:0]
  - constant BCD_MAX = 4'd9
  - constant BCD_CORR = 5'd6
- One natural sub-module: sumador_digito_bcd, a combinational single-digit adder.
  - Inputs: a, b, cin. Outputs: digit, cout.
  - Instantiated once and reused each cycle under idx selection.

Test Plan:
- 1234 + 5678, suma pulse 1 cycle → ocupado for 4 cycles, listo exactly 5 cycles after the suma edge, resultado=0_6_9_1_2.
- 9999 + 9999 → resultado=1_9_9_9_8 (carry ripples through every digit), listo pulse width exactly 1 cycle.
- 0000 + 0000, then 0005 + 0005 back-to-back (suma on the first REPOSO cycle after FIN) → 00000 then 00010, two separate listo pulses.
- Start 1111 + 2222; in cycle 2 pulse suma with other operands; in cycle 3 change operando_b → resultado=03333, single listo, second suma ignored.
- Start 4321 + 1234; assert rst (and separately rst_sv) in cycle 2 → next cycle resultado=0, ocupado=0, no listo ever issued for that operation.
- With SUMA_BCD_CHECK_EN: operando_a digit = 4'hA → error_bcd=1 from the cycle after suma until the next valid suma; without the macro, error_bcd stays 0.

Source files
------------

// File: rtl/suma_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package suma_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_suma_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX  = 4'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

endpackage

// File: rtl/sumador_digito_bcd.sv
// Combinational single-digit BCD adder with decimal carry correction.
module sumador_digito_bcd
  import suma_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t digit,
  output logic cout
);

  logic [4:0] s_c;

  always_comb begin
    s_c   = 5'(a) + 5'(b) + 5'(cin);
    digit = s_c[3:0];
    cout  = 1'b0;
    if (s_c > 5'(BCD_MAX)) begin
      digit = 4'(s_c + BCD_CORR);
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/suma_bcd_serial.sv
// Digit-serial BCD adder, LSD first, one digit per clock.
// Optional operand digit checking enabled by macro SUMA_BCD_CHECK_EN.
module suma_bcd_serial
  import suma_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_DIGITS-1:0][3:0]   operando_a,
  input  logic [N_DIGITS-1:0][3:0]   operando_b,
  input  logic                       suma,
  input  logic                       rst_sv,
  output logic [N_DIGITS:0][3:0]     resultado,
  output logic                       ocupado,
  output logic                       listo,
  output logic                       error_bcd
);

  localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned RES_IDX_W = $clog2(N_DIGITS + 1);

  estado_suma_t estado_q, estado_d;

  logic                     carga_c, paso_c, ultimo_c, cierre_c;
  logic                     clr_c;
  bcd_t [N_DIGITS-1:0]      a_q, b_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     carry_q;
  bcd_t                     digito_c;
  logic                     cout_c;

  assign clr_c = rst | rst_sv;

  sumador_digito_bcd u_sumador (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .digit (digito_c),
    .cout  (cout_c)
  );

  always_ff @(posedge clk) begin
    if (clr_c) estado_q <= REPOSO;
    else       estado_q <= estado_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    estado_d = estado_q;
    carga_c  = 1'b0;
    paso_c   = 1'b0;
    ultimo_c = 1'b0;
    cierre_c = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (suma) begin
          carga_c  = 1'b1;
          estado_d = SUMANDO;
        end
      end
      SUMANDO: begin
        paso_c = 1'b1;
        if (idx_q == IDX_W'(N_DIGITS - 1)) begin
          ultimo_c = 1'b1;
          estado_d = FIN;
        end
      end
      FIN: begin
        cierre_c = 1'b1;
        estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_c) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      resultado <= '0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
    end else begin
      listo <= cierre_c;
      if (carga_c) begin
        a_q       <= operando_a;
        b_q       <= operando_b;
        idx_q     <= '0;
        carry_q   <= 1'b0;
        resultado <= '0;
        ocupado   <= 1'b1;
      end
      if (paso_c) begin
        resultado[RES_IDX_W'(idx_q)] <= digito_c;
        carry_q                      <= cout_c;
        idx_q                        <= ultimo_c ? '0 : idx_q + IDX_W'(1);
        if (ultimo_c) ocupado <= 1'b0;
      end
      // Final carry becomes the top digit together with the listo strobe
      if (cierre_c) resultado[N_DIGITS] <= {3'b000, carry_q};
    end
  end

`ifdef SUMA_BCD_CHECK_EN
  logic hay_invalido_c;

  always_comb begin
    hay_invalido_c = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (operando_a[i] > BCD_MAX || operando_b[i] > BCD_MAX) hay_invalido_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_c)        error_bcd <= 1'b0;
    else if (carga_c) error_bcd <= hay_invalido_c;
  end
`else
  assign error_bcd = 1'b0;
`endif

endmodule

// File: tb/tb_suma_bcd_serial.sv
// Self-checking bench for suma_bcd_serial against a decimal-arithmetic model.
module tb_suma_bcd_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_sv;
  logic        suma;
  logic [15:0] operando_a;
  logic [15:0] operando_b;
  logic [19:0] resultado;
  logic        ocupado;
  logic        listo;
  logic        error_bcd;

  int n_checks = 0;
  int n_fails  = 0;

  suma_bcd_serial #(.N_DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .suma       (suma),
    .rst_sv     (rst_sv),
    .resultado  (resultado),
    .ocupado    (ocupado),
    .listo      (listo),
    .error_bcd  (error_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as decimal numbers, add, re-encode as 5 BCD digits
  function automatic logic [19:0] modelo(input logic [15:0] a, input logic [15:0] b);
    int va = 0, vb = 0, peso = 1, s;
    logic [19:0] r;
    for (int i = 0; i < 4; i++) begin
      va += int'(a[i*4 +: 4]) * peso;
      vb += int'(b[i*4 +: 4]) * peso;
      peso *= 10;
    end
    s = va + vb;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_aleatorio();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge (k=0)
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
    operando_a = a;
    operando_b = b;
    suma       = 1'b1;
    @(negedge clk);
    suma       = 1'b0;
    operando_a = 16'($urandom);
    operando_b = 16'($urandom);
  endtask

  // Returns at the negedge where listo is seen; lat counts negedges since the accepting edge
  task automatic wait_listo(input int k0, output int lat, output int ocup);
    int k = k0;
    ocup = 0;
    while (!listo && k < 30) begin
      if (ocupado) ocup++;
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  task automatic sumar(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat, ocup;
    pulse_start(a, b);
    wait_listo(0, lat, ocup);
    check({tag, "_latencia"}, 32'(lat), 32'd5);
    check({tag, "_ocupado"}, 32'(ocup), 32'd4);
    check({tag, "_resultado"}, 32'(resultado), 32'(modelo(a, b)));
  endtask

  task automatic contar_listo(input int ciclos, output int n);
    n = 0;
    for (int i = 0; i < ciclos; i++) begin
      @(negedge clk);
      if (listo) n++;
    end
  endtask

  initial begin
    int lat, ocup, n;
    logic [19:0] guardado;
    logic        err_esp;

    rst = 1'b1; rst_sv = 1'b0; suma = 1'b0;
    operando_a = '0; operando_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_resultado", 32'(resultado), 32'd0);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_listo", 32'(listo), 32'd0);
    check("reset_error", 32'(error_bcd), 32'd0);

    @(negedge clk);
    sumar("s1234_5678", 16'h1234, 16'h5678);
    check("s1234_literal", 32'(resultado), 32'h06912);

    sumar("s9999_9999", 16'h9999, 16'h9999);
    check("s9999_literal", 32'(resultado), 32'h19998);
    check("s9999_error", 32'(error_bcd), 32'd0);
    @(negedge clk);
    check("s9999_ancho_listo", 32'(listo), 32'd0);
    check("s9999_retenido", 32'(resultado), 32'h19998);

    // Back-to-back: second suma driven in the cycle listo is high
    sumar("s0000", 16'h0000, 16'h0000);
    sumar("s0005", 16'h0005, 16'h0005);
    check("s0005_literal", 32'(resultado), 32'h00010);

    // Second suma mid-operation is ignored; later operand changes do not matter
    @(negedge clk);
    pulse_start(16'h1111, 16'h2222);
    @(negedge clk);
    operando_a = bcd_aleatorio();
    operando_b = bcd_aleatorio();
    suma = 1'b1;
    @(negedge clk);
    suma = 1'b0;
    operando_b = bcd_aleatorio();
    wait_listo(2, lat, ocup);
    check("ignorado_latencia", 32'(lat), 32'd5);
    check("ignorado_resultado", 32'(resultado), 32'h03333);
    guardado = resultado;
    contar_listo(10, n);
    check("ignorado_sin_listo_extra", 32'(n), 32'd0);
    check("ignorado_retenido", 32'(resultado), 32'(guardado));

    // Abort via rst and via rst_sv
    for (int r = 0; r < 2; r++) begin
      pulse_start(16'h4321, 16'h1234);
      @(negedge clk);
      if (r == 0) rst = 1'b1; else rst_sv = 1'b1;
      @(negedge clk);
      rst = 1'b0; rst_sv = 1'b0;
      check("abort_resultado", 32'(resultado), 32'd0);
      check("abort_ocupado", 32'(ocupado), 32'd0);
      check("abort_listo", 32'(listo), 32'd0);
      contar_listo(10, n);
      check("abort_sin_listo", 32'(n), 32'd0);
    end

    // Randomised valid operands
    for (int i = 0; i < 20; i++) begin
      sumar("aleatorio", bcd_aleatorio(), bcd_aleatorio());
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    // Invalid digit flag
`ifdef SUMA_BCD_CHECK_EN
    err_esp = 1'b1;
`else
    err_esp = 1'b0;
`endif
    @(negedge clk);
    pulse_start(16'h00A0, 16'h1234);
    check("error_tras_suma", 32'(error_bcd), 32'(err_esp));
    wait_listo(0, lat, ocup);
    check("error_latencia", 32'(lat), 32'd5);
    check("error_retenido", 32'(error_bcd), 32'(err_esp));
    @(negedge clk);
    pulse_start(16'h0012, 16'h0034);
    check("error_limpio", 32'(error_bcd), 32'd0);
    wait_listo(0, lat, ocup);
    check("error_limpio_resultado", 32'(resultado), 32'h00046);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
